// File: rtl/instr_seq.sv
// instr_seq: MSP430 instruction sequencer; Moore FSM driving the register file, memory bus and PC strobes.
// Optional feature macro: INSTR_SEQ_AUTOINC_EN enables the AUTOINC state for @Rn+ sources.
module instr_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] mdb_in,
   input  logic        mem_ready,
   output logic [3:0]  SA,
   output logic [3:0]  DA,
   output logic [1:0]  As,
   output logic        RW,
   output logic [15:0] ir_out,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [1:0]  mab_sel,
   output logic        ext_ld,
   output logic        pc_inc,
   output logic        pc_load,
   output logic [3:0]  state
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_FETCH   = 4'd1;
   localparam logic [3:0] S_DECODE  = 4'd2;
   localparam logic [3:0] S_SRC_EXT = 4'd3;
   localparam logic [3:0] S_SRC_RD  = 4'd4;
   localparam logic [3:0] S_AUTOINC = 4'd5;
   localparam logic [3:0] S_DST_EXT = 4'd6;
   localparam logic [3:0] S_DST_RD  = 4'd7;
   localparam logic [3:0] S_EXEC    = 4'd8;
   localparam logic [3:0] S_DST_WR  = 4'd9;

   logic [3:0]  state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic        src_ext_q, src_ext_d;
   logic        pc_inc_q, pc_inc_d;
   logic        ext_ld_q, ext_ld_d;

   logic        is_jump, is_fmt1, is_fmt2, is_cg, no_wb, dst_mem;
   logic [3:0]  sa_f;
   logic [1:0]  as_f;
   logic [3:0]  dst_path;

   assign is_jump  = (ir_q[15:13] == 3'b001);
   assign is_fmt2  = (ir_q[15:10] == 6'b000100);
   assign is_fmt1  = (ir_q[15:12] >= 4'd4);
   assign sa_f     = is_fmt1 ? ir_q[11:8] : ir_q[3:0];
   assign as_f     = is_jump ? 2'b00 : ir_q[5:4];
   assign is_cg    = (sa_f == 4'd2) || (sa_f == 4'd3);
   assign no_wb    = is_fmt1 && ((ir_q[15:12] == 4'h9) || (ir_q[15:12] == 4'hB));
   assign dst_mem  = is_fmt1 && ir_q[7];
   assign dst_path = dst_mem ? S_DST_EXT : S_EXEC;

   // mem_rd/mem_wr are the request valid, mem_ready the ready: a request and its mab_sel stay
   // unchanged until a cycle with mem_ready high, which completes it. ext_ld/pc_inc follow that
   // cycle; mdb_in holds the completed read word until the next completion.
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      src_ext_d = src_ext_q;
      pc_inc_d  = 1'b0;
      ext_ld_d  = 1'b0;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: begin
            if (mem_ready) begin
               ir_d     = mdb_in;
               pc_inc_d = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            src_ext_d = 1'b0;
            if (is_jump)                      state_d = S_EXEC;
            else if (!(is_fmt1 || is_fmt2))   state_d = S_FETCH;
            else if (is_cg || as_f == 2'b00)  state_d = dst_path;
            else if (as_f == 2'b01)           state_d = S_SRC_EXT;
            else                              state_d = S_SRC_RD;
         end
         S_SRC_EXT: begin
            if (mem_ready) begin
               ext_ld_d  = 1'b1;
               pc_inc_d  = 1'b1;
               src_ext_d = 1'b1;
               state_d   = S_SRC_RD;
            end
         end
         S_SRC_RD: begin
            if (mem_ready) begin
`ifdef INSTR_SEQ_AUTOINC_EN
               state_d = (as_f == 2'b11) ? S_AUTOINC : dst_path;
`else
               state_d = dst_path;
`endif
            end
         end
         S_AUTOINC: state_d = dst_path;
         S_DST_EXT: begin
            if (mem_ready) begin
               ext_ld_d = 1'b1;
               pc_inc_d = 1'b1;
               state_d  = S_DST_RD;
            end
         end
         S_DST_RD: if (mem_ready) state_d = S_EXEC;
         S_EXEC:   state_d = (dst_mem && !no_wb) ? S_DST_WR : S_FETCH;
         S_DST_WR: if (mem_ready) state_d = S_FETCH;
         default:  state_d = S_IDLE;
      endcase
   end

   // pc_load is raised for every jump; the external condition logic qualifies it.
   always_comb begin
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      mab_sel = 2'b00;
      RW      = 1'b0;
      pc_load = 1'b0;
      DA      = ir_q[3:0];
      case (state_q)
         S_FETCH, S_SRC_EXT, S_DST_EXT: mem_rd = 1'b1;
         S_SRC_RD: begin
            mem_rd  = 1'b1;
            mab_sel = src_ext_q ? 2'b10 : 2'b01;
         end
         S_AUTOINC: begin
            RW = 1'b1;
            DA = sa_f;
         end
         S_DST_RD: begin
            mem_rd  = 1'b1;
            mab_sel = 2'b11;
         end
         S_EXEC: begin
            pc_load = is_jump;
            RW      = (is_fmt1 || is_fmt2) && !dst_mem && !no_wb;
         end
         S_DST_WR: begin
            mem_wr  = 1'b1;
            mab_sel = 2'b11;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ir_q      <= 16'h0000;
         src_ext_q <= 1'b0;
         pc_inc_q  <= 1'b0;
         ext_ld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         src_ext_q <= src_ext_d;
         pc_inc_q  <= pc_inc_d;
         ext_ld_q  <= ext_ld_d;
      end
   end

   assign SA     = sa_f;
   assign As     = as_f;
   assign ir_out = ir_q;
   assign pc_inc = pc_inc_q;
   assign ext_ld = ext_ld_q;
   assign state  = state_q;

endmodule
